// File: rtl/change_dispenser_if.sv
// change_dispenser_if: vending-FSM and hopper-side signals of the change dispenser.
// master drives requests, acks and refills; slave is the dispenser controller.
interface change_dispenser_if #(
    parameter int AMT_W = 8,
    parameter int INV_W = 6
);
    logic             change_req;
    logic [AMT_W-1:0] change_amt;
    logic             coin_ack;
    logic             refill_50;
    logic             refill_10;
    logic             eject_50;
    logic             eject_10;
    logic             busy;
    logic             done;
    logic             short;
    logic [AMT_W-1:0] short_amt;
    logic             jam;
    logic [INV_W-1:0] inv50;
    logic [INV_W-1:0] inv10;
    modport master (
        output change_req, change_amt, coin_ack, refill_50, refill_10,
        input  eject_50, eject_10, busy, done, short, short_amt, jam, inv50, inv10
    );
    modport slave (
        input  change_req, change_amt, coin_ack, refill_50, refill_10,
        output eject_50, eject_10, busy, done, short, short_amt, jam, inv50, inv10
    );
endinterface

// File: rtl/change_dispenser_ctrl.sv
// change_dispenser_ctrl: pays change one coin per hopper ack, $50 first, $10 fallback, reports shortfall.
// Optional CHANGE_JAM_DETECT_EN: an ack timeout enters a sticky FAULT state and raises jam.
module change_dispenser_ctrl #(
    parameter int AMT_W       = 8,
    parameter int INV_W       = 6,
    parameter int INV50_INIT  = 10,
    parameter int INV10_INIT  = 20,
    parameter int ACK_TIMEOUT = 15
) (
    input logic               clk,
    input logic               reset,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE, DECIDE, EJECT, WAIT_ACK, DONE
`ifdef CHANGE_JAM_DETECT_EN
        , FAULT
`endif
    } state_t;

    localparam logic [AMT_W-1:0] C50 = AMT_W'(5);
    localparam logic [AMT_W-1:0] C10 = AMT_W'(1);

    state_t           state, state_d;
    logic [AMT_W-1:0] rem, short_amt;
    logic [INV_W-1:0] inv50, inv10;
    logic             sel50, short_f, pick50, pick10, timeout, eject_50, eject_10;

    // Refill and eject in the same cycle cancel; refills saturate at full scale.
    function automatic logic [INV_W-1:0] inv_upd(input logic [INV_W-1:0] c, input logic inc, input logic dec);
        return (inc && !dec && c != '1) ? c + 1'b1 : (dec && !inc) ? c - 1'b1 : c;
    endfunction

    assign pick50   = rem >= C50 && inv50 != '0;
    assign pick10   = rem != '0 && inv10 != '0;
    assign eject_50 = state == EJECT && sel50;
    assign eject_10 = state == EJECT && !sel50;

    always_ff @(posedge clk)
        state <= !reset ? IDLE : state_d;

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = bus.change_req ? DECIDE : IDLE;
            DECIDE:   state_d = (pick50 || pick10) ? EJECT : DONE;
            EJECT:    state_d = WAIT_ACK;
`ifdef CHANGE_JAM_DETECT_EN
            WAIT_ACK: state_d = bus.coin_ack ? DECIDE : timeout ? FAULT : WAIT_ACK;
`else
            WAIT_ACK: state_d = bus.coin_ack ? DECIDE : WAIT_ACK;
`endif
            DONE:     state_d = IDLE;
            default:  state_d = state;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rem       <= '0;
            sel50     <= 1'b0;
            short_f   <= 1'b0;
            short_amt <= '0;
            inv50     <= INV_W'(INV50_INIT);
            inv10     <= INV_W'(INV10_INIT);
        end else begin
            if (state == IDLE && bus.change_req) begin
                rem       <= bus.change_amt;
                short_f   <= 1'b0;
                short_amt <= '0;
            end
            if (state == DECIDE)
                sel50 <= pick50;
            if ((state == DECIDE && !pick50 && !pick10 && rem != '0) || timeout) begin
                short_f   <= 1'b1;
                short_amt <= rem;
            end
            if (state == WAIT_ACK && bus.coin_ack)
                rem <= rem - (sel50 ? C50 : C10);
            inv50 <= inv_upd(inv50, bus.refill_50, eject_50);
            inv10 <= inv_upd(inv10, bus.refill_10, eject_10);
        end
    end

`ifdef CHANGE_JAM_DETECT_EN
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    logic [TW-1:0] tmr;
    logic          jam, fault_done;
    assign timeout = state == WAIT_ACK && !bus.coin_ack && tmr == TW'(ACK_TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (!reset) begin
            tmr        <= '0;
            jam        <= 1'b0;
            fault_done <= 1'b0;
        end else begin
            tmr        <= state == WAIT_ACK ? tmr + 1'b1 : '0;
            jam        <= jam | timeout;
            fault_done <= timeout;
        end
    end
    assign bus.jam  = jam;
    assign bus.done = state == DONE || fault_done;
`else
    assign timeout  = 1'b0;
    assign bus.jam  = 1'b0;
    assign bus.done = state == DONE;
`endif

    assign bus.eject_50  = eject_50;
    assign bus.eject_10  = eject_10;
    assign bus.busy      = state != IDLE;
    assign bus.short     = short_f;
    assign bus.short_amt = short_amt;
    assign bus.inv50     = inv50;
    assign bus.inv10     = inv10;
endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// tb_change_dispenser_ctrl: directed scenarios for the change dispenser controller.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_change_dispenser_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_pass = 0;
    int   n_chk = 0;
    int   r50, r10, rfirst, rdone;
    logic rfirst50, rsh, rbusy;
    logic [7:0] rsa;

    change_dispenser_if #(.AMT_W(8), .INV_W(6)) bus ();
    change_dispenser_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    // Requests amt, acks each coin three cycles after its eject, returns when done is seen.
    task automatic payout(input logic [7:0] amt);
        int ack_in;
        r50 = 0; r10 = 0; rfirst = -1; rdone = -1; rbusy = 1'b1; rfirst50 = 1'b0;
        rsh = 1'bx; rsa = 'x; ack_in = -1;
        bus.change_req = 1'b1;
        bus.change_amt = amt;
        for (int c = 1; c <= 300 && rdone < 0; c++) begin
            @(negedge clk);
            bus.change_req = 1'b0;
            bus.coin_ack = (ack_in == 0);
            if (ack_in >= 0) ack_in--;
            if (bus.eject_50 || bus.eject_10) begin
                if (rfirst < 0) begin rfirst = c; rfirst50 = bus.eject_50; end
                ack_in = 2;
            end
            if (bus.eject_50) r50++;
            if (bus.eject_10) r10++;
            if (!bus.busy) rbusy = 1'b0;
            if (bus.done) begin rdone = c; rsh = bus.short; rsa = bus.short_amt; end
        end
        @(negedge clk);
        bus.coin_ack = 1'b0;
        n_chk++; if (rdone < 0) $display("FAIL payout_done amt=%0d: got no done, want done", amt); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL payout_idle amt=%0d: got busy=%b, want 0", amt, bus.busy); else n_pass++;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_chk++; if (bus.inv50 !== 6'd10) $display("FAIL rst_inv50: got %0d, want 10", bus.inv50); else n_pass++;
        n_chk++; if (bus.inv10 !== 6'd20) $display("FAIL rst_inv10: got %0d, want 20", bus.inv10); else n_pass++;
        n_chk++; if ({bus.eject_50, bus.eject_10, bus.busy, bus.done, bus.short, bus.jam} !== 6'b0)
            $display("FAIL rst_flags: got %b, want 000000", {bus.eject_50, bus.eject_10, bus.busy, bus.done, bus.short, bus.jam}); else n_pass++;
        n_chk++; if (bus.short_amt !== 8'd0) $display("FAIL rst_short_amt: got %0d, want 0", bus.short_amt); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL rst_release_busy: got %b, want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_mixed();
        payout(8'd8);
        n_chk++; if (r50 !== 1) $display("FAIL mix_n50: got %0d, want 1", r50); else n_pass++;
        n_chk++; if (r10 !== 3) $display("FAIL mix_n10: got %0d, want 3", r10); else n_pass++;
        n_chk++; if (rfirst50 !== 1'b1) $display("FAIL mix_first_is_50: got %b, want 1", rfirst50); else n_pass++;
        n_chk++; if (rfirst < 2 || rfirst > 3) $display("FAIL mix_latency: got %0d, want 2..3", rfirst); else n_pass++;
        n_chk++; if (rsh !== 1'b0) $display("FAIL mix_short: got %b, want 0", rsh); else n_pass++;
        n_chk++; if (rbusy !== 1'b1) $display("FAIL mix_busy: got %b, want 1", rbusy); else n_pass++;
        n_chk++; if (bus.inv50 !== 6'd9) $display("FAIL mix_inv50: got %0d, want 9", bus.inv50); else n_pass++;
        n_chk++; if (bus.inv10 !== 6'd17) $display("FAIL mix_inv10: got %0d, want 17", bus.inv10); else n_pass++;
    endtask

    task automatic test_fallback();
        for (int i = 0; i < 9; i++) begin
            payout(8'd5);
            n_chk++; if (r50 !== 1 || r10 !== 0) $display("FAIL drain50_%0d: got %0d/%0d, want 1/0", i, r50, r10); else n_pass++;
        end
        n_chk++; if (bus.inv50 !== 6'd0) $display("FAIL drain_inv50: got %0d, want 0", bus.inv50); else n_pass++;
        payout(8'd5);
        n_chk++; if (r50 !== 0) $display("FAIL fb_n50: got %0d, want 0", r50); else n_pass++;
        n_chk++; if (r10 !== 5) $display("FAIL fb_n10: got %0d, want 5", r10); else n_pass++;
        n_chk++; if (rsh !== 1'b0) $display("FAIL fb_short: got %b, want 0", rsh); else n_pass++;
        n_chk++; if (bus.inv10 !== 6'd12) $display("FAIL fb_inv10: got %0d, want 12", bus.inv10); else n_pass++;
    endtask

    task automatic test_zero();
        payout(8'd0);
        n_chk++; if (r50 + r10 !== 0) $display("FAIL zero_ejects: got %0d, want 0", r50 + r10); else n_pass++;
        n_chk++; if (rdone < 2 || rdone > 3) $display("FAIL zero_done_cycle: got %0d, want 2..3", rdone); else n_pass++;
        n_chk++; if (rbusy !== 1'b1) $display("FAIL zero_busy: got %b, want 1", rbusy); else n_pass++;
        n_chk++; if (rsh !== 1'b0) $display("FAIL zero_short: got %b, want 0", rsh); else n_pass++;
    endtask

    task automatic test_short();
        payout(8'd10);
        n_chk++; if (r10 !== 10 || r50 !== 0) $display("FAIL sh_drain: got %0d/%0d, want 0/10", r50, r10); else n_pass++;
        n_chk++; if (bus.inv10 !== 6'd2) $display("FAIL sh_inv10_pre: got %0d, want 2", bus.inv10); else n_pass++;
        payout(8'd3);
        n_chk++; if (r10 !== 2) $display("FAIL sh_n10: got %0d, want 2", r10); else n_pass++;
        n_chk++; if (rsh !== 1'b1) $display("FAIL sh_short: got %b, want 1", rsh); else n_pass++;
        n_chk++; if (rsa !== 8'd1) $display("FAIL sh_short_amt: got %0d, want 1", rsa); else n_pass++;
        n_chk++; if (bus.short_amt !== 8'd1) $display("FAIL sh_short_amt_held: got %0d, want 1", bus.short_amt); else n_pass++;
        payout(8'd7);
        n_chk++; if (r50 + r10 !== 0) $display("FAIL sh_empty_ejects: got %0d, want 0", r50 + r10); else n_pass++;
        n_chk++; if (rsh !== 1'b1 || rsa !== 8'd7) $display("FAIL sh_empty: got %b/%0d, want 1/7", rsh, rsa); else n_pass++;
        payout(8'd0);
        n_chk++; if (rsh !== 1'b0 || rsa !== 8'd0) $display("FAIL sh_cleared: got %b/%0d, want 0/0", rsh, rsa); else n_pass++;
    endtask

    task automatic test_busy_refill();
        int n;
        bus.refill_10 = 1'b1;
        bus.refill_50 = 1'b1;
        @(negedge clk);
        bus.refill_50 = 1'b0;
        repeat (2) @(negedge clk);
        bus.refill_10 = 1'b0;
        n_chk++; if (bus.inv10 !== 6'd3 || bus.inv50 !== 6'd1) $display("FAIL refill: got %0d/%0d, want 1/3", bus.inv50, bus.inv10); else n_pass++;
        bus.change_req = 1'b1;
        bus.change_amt = 8'd2;
        @(negedge clk);
        bus.change_req = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.eject_10 !== 1'b1) $display("FAIL br_eject10: got %b, want 1", bus.eject_10); else n_pass++;
        bus.refill_10 = 1'b1;
        bus.change_req = 1'b1;
        bus.change_amt = 8'd50;
        @(negedge clk);
        bus.refill_10 = 1'b0;
        bus.change_req = 1'b0;
        n_chk++; if (bus.inv10 !== 6'd3) $display("FAIL br_refill_eject: got %0d, want 3", bus.inv10); else n_pass++;
        bus.coin_ack = 1'b1;
        @(negedge clk);
        bus.coin_ack = 1'b0;
        n = 0;
        for (int c = 0; c < 50 && bus.done !== 1'b1; c++) begin
            @(negedge clk);
            if (bus.eject_10 || bus.eject_50) begin
                n++;
                @(negedge clk); bus.coin_ack = 1'b1;
                @(negedge clk); bus.coin_ack = 1'b0;
            end
        end
        n_chk++; if (n !== 1) $display("FAIL br_remaining: got %0d, want 1", n); else n_pass++;
        n_chk++; if (bus.done !== 1'b1 || bus.short !== 1'b0) $display("FAIL br_done: got %b/%b, want 1/0", bus.done, bus.short); else n_pass++;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (bus.eject_10 || bus.eject_50 || bus.busy) n++;
        end
        n_chk++; if (n !== 0) $display("FAIL br_dropped_req: got %0d active cycles, want 0", n); else n_pass++;
        n_chk++; if (bus.inv50 !== 6'd1 || bus.inv10 !== 6'd2) $display("FAIL br_inv: got %0d/%0d, want 1/2", bus.inv50, bus.inv10); else n_pass++;
    endtask

    task automatic test_reset_abort();
        int n;
        bus.change_req = 1'b1;
        bus.change_amt = 8'd1;
        @(negedge clk);
        bus.change_req = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.eject_10 !== 1'b1) $display("FAIL ra_eject: got %b, want 1", bus.eject_10); else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL ra_idle: got %b/%b, want 0/0", bus.busy, bus.done); else n_pass++;
        n_chk++; if (bus.inv50 !== 6'd10 || bus.inv10 !== 6'd20) $display("FAIL ra_inv: got %0d/%0d, want 10/20", bus.inv50, bus.inv10); else n_pass++;
        reset = 1'b1;
        bus.coin_ack = 1'b1;
        n = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus.coin_ack = 1'b0;
            if (bus.eject_10 || bus.eject_50 || bus.busy || bus.done) n++;
        end
        n_chk++; if (n !== 0) $display("FAIL ra_quiet: got %0d active cycles, want 0", n); else n_pass++;
    endtask

    task automatic test_saturation();
        bus.refill_50 = 1'b1;
        bus.refill_10 = 1'b1;
        @(negedge clk);
        bus.refill_10 = 1'b0;
        repeat (59) @(negedge clk);
        bus.refill_50 = 1'b0;
        n_chk++; if (bus.inv50 !== 6'd63) $display("FAIL sat_inv50: got %0d, want 63", bus.inv50); else n_pass++;
        n_chk++; if (bus.inv10 !== 6'd21) $display("FAIL sat_inv10: got %0d, want 21", bus.inv10); else n_pass++;
    endtask

`ifdef CHANGE_JAM_DETECT_EN
    task automatic test_jam();
        int ne, nd, dc, nb;
        logic jm, sh;
        logic [7:0] sa;
        ne = 0; nd = 0; dc = -1; nb = 0; jm = 1'b0; sh = 1'b0; sa = '0;
        bus.change_req = 1'b1;
        bus.change_amt = 8'd5;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.change_req = (c == 30);
            if (bus.eject_50 || bus.eject_10) ne++;
            if (bus.done) begin
                nd++;
                if (dc < 0) begin dc = c; jm = bus.jam; sh = bus.short; sa = bus.short_amt; end
            end
            if (!bus.busy) nb++;
        end
        bus.change_req = 1'b0;
        n_chk++; if (ne !== 1) $display("FAIL jam_ejects: got %0d, want 1", ne); else n_pass++;
        n_chk++; if (dc !== 18) $display("FAIL jam_done_cycle: got %0d, want 18", dc); else n_pass++;
        n_chk++; if (nd !== 1) $display("FAIL jam_done_count: got %0d, want 1", nd); else n_pass++;
        n_chk++; if (jm !== 1'b1 || sh !== 1'b1 || sa !== 8'd5) $display("FAIL jam_flags: got %b/%b/%0d, want 1/1/5", jm, sh, sa); else n_pass++;
        n_chk++; if (nb !== 0 || bus.jam !== 1'b1) $display("FAIL jam_sticky: got idle=%0d jam=%b, want 0/1", nb, bus.jam); else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_chk++; if (bus.jam !== 1'b0 || bus.busy !== 1'b0) $display("FAIL jam_reset: got %b/%b, want 0/0", bus.jam, bus.busy); else n_pass++;
    endtask
`endif

    initial begin
        bus.change_req = 1'b0;
        bus.change_amt = '0;
        bus.coin_ack   = 1'b0;
        bus.refill_50  = 1'b0;
        bus.refill_10  = 1'b0;
        test_reset();
        test_mixed();
        test_fallback();
        test_zero();
        test_short();
        test_busy_refill();
        test_reset_abort();
        test_saturation();
`ifdef CHANGE_JAM_DETECT_EN
        test_jam();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
